// File: rtl/unidade_busca.sv
// unidade_busca
// Instruction-fetch stage for the 8-bit Redux-V datapath. It owns the program
// counter, drives the instruction memory address and captures the memory's
// combinational output into an instruction register for the decoder. It also
// handles start, stall, branch redirect and the end-of-program halt.
//
// Parameters:
//   ENDERECO_INICIAL     PC value loaded at reset and on every start
//   ENDERECO_FIM         address of the last program instruction
//
// Ports:
//   clock                system clock, rising edge
//   reset_n              asynchronous reset, active low
//   iniciar              start pulse, honoured only when idle or halted
//   habilita             fetch enable (0 = stall)
//   desvio               branch taken, from downstream
//   endereco_desvio      branch target address
//   instrucao_mem        instruction memory data, combinational on endereco
//   endereco             instruction memory address (copy of the PC)
//   instrucao            instruction register
//   valida               instrucao was newly captured on the last edge
//   parado               run finished
//   contador_instrucoes  valid fetches since last start, saturating at 255
module unidade_busca #(
    parameter logic [7:0] ENDERECO_INICIAL = 8'd0,
    parameter logic [7:0] ENDERECO_FIM     = 8'd39
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       habilita,
    input  logic       desvio,
    input  logic [7:0] endereco_desvio,
    input  logic [7:0] instrucao_mem,
    output logic [7:0] endereco,
    output logic [7:0] instrucao,
    output logic       valida,
    output logic       parado,
    output logic [7:0] contador_instrucoes
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] BUSCA  = 2'd1;
    localparam logic [1:0] PARADO = 2'd2;

    logic [1:0] r_estado;
    logic [7:0] r_pc;
    logic [7:0] r_instrucao;
    logic       r_valida;
    logic       r_parado;
    logic [7:0] r_contador;

    logic [7:0] w_contador_inc;

    // The fetch counter sticks at 255 instead of wrapping.
    assign w_contador_inc = (r_contador == 8'hFF) ? r_contador : r_contador + 8'd1;

    // Fetch state machine. Inside BUSCA a branch beats a stall, and a stall
    // beats a normal fetch; the halt check is only made on a real fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= OCIOSO;
            r_pc        <= ENDERECO_INICIAL;
            r_instrucao <= 8'h00;
            r_valida    <= 1'b0;
            r_parado    <= 1'b0;
            r_contador  <= 8'h00;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_valida <= 1'b0;
                    r_parado <= 1'b0;
                    if (iniciar) begin
                        r_pc       <= ENDERECO_INICIAL;
                        r_contador <= 8'h00;
                        r_estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    if (desvio) begin
                        r_pc     <= endereco_desvio;
                        r_valida <= 1'b0;
                    end else if (!habilita) begin
                        r_valida <= 1'b0;
                    end else begin
                        r_instrucao <= instrucao_mem;
                        r_valida    <= 1'b1;
                        r_contador  <= w_contador_inc;
                        if (r_pc == ENDERECO_FIM) begin
                            // PC stays on the last instruction once halted.
                            r_parado <= 1'b1;
                            r_estado <= PARADO;
                        end else begin
                            r_pc <= r_pc + 8'd1;
                        end
                    end
                end
                PARADO: begin
                    r_valida <= 1'b0;
                    if (iniciar) begin
                        r_parado   <= 1'b0;
                        r_pc       <= ENDERECO_INICIAL;
                        r_contador <= 8'h00;
                        r_estado   <= BUSCA;
                    end
                end
                default: begin
                    r_valida <= 1'b0;
                    r_parado <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign endereco            = r_pc;
    assign instrucao           = r_instrucao;
    assign valida              = r_valida;
    assign parado              = r_parado;
    assign contador_instrucoes = r_contador;

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca
// Bench for unidade_busca. Two instances share the clock and control inputs:
// A uses the default program window (0..39), B the Alg2 window (41..100).
// Each reads its own port of a shared combinational instruction memory.
module tb_unidade_busca;

    logic       clock = 1'b0;
    logic       resetN;
    logic       iniciar;
    logic       habilita;
    logic       desvio;
    logic [7:0] enderecoDesvio;

    logic [7:0] enderecoA, instrucaoA, contadorA, instrucaoMemA;
    logic       validaA, paradoA;
    logic [7:0] enderecoB, instrucaoB, contadorB, instrucaoMemB;
    logic       validaB, paradoB;

    logic [7:0] mem [256];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: one entry per instance. runState 0 = idle,
    // 1 = fetching, 2 = finished.
    int runState [2];
    int mPc      [2];
    int mIns     [2];
    int mVal     [2];
    int mCnt     [2];
    int mIni     [2] = '{0, 41};
    int mFim     [2] = '{39, 100};

    assign instrucaoMemA = mem[enderecoA];
    assign instrucaoMemB = mem[enderecoB];

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    unidade_busca dutA (
        .clock               (clock),
        .reset_n             (resetN),
        .iniciar             (iniciar),
        .habilita            (habilita),
        .desvio              (desvio),
        .endereco_desvio     (enderecoDesvio),
        .instrucao_mem       (instrucaoMemA),
        .endereco            (enderecoA),
        .instrucao           (instrucaoA),
        .valida              (validaA),
        .parado              (paradoA),
        .contador_instrucoes (contadorA)
    );

    unidade_busca #(
        .ENDERECO_INICIAL (8'd41),
        .ENDERECO_FIM     (8'd100)
    ) dutB (
        .clock               (clock),
        .reset_n             (resetN),
        .iniciar             (iniciar),
        .habilita            (habilita),
        .desvio              (desvio),
        .endereco_desvio     (enderecoDesvio),
        .instrucao_mem       (instrucaoMemB),
        .endereco            (enderecoB),
        .instrucao           (instrucaoB),
        .valida              (validaB),
        .parado              (paradoB),
        .contador_instrucoes (contadorB)
    );

    // One comparison: count it, and report it when it does not hold.
    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            runState[k] = 0;
            mPc[k]      = mIni[k];
            mIns[k]     = 0;
            mVal[k]     = 0;
            mCnt[k]     = 0;
        end
    endtask

    // Advance the model of instance k by one clock edge.
    task automatic modelEdge(input int k, input bit ini, input bit hab, input bit des, input int tgt);
        if (runState[k] == 1) begin
            if (des) begin
                mPc[k]  = tgt;
                mVal[k] = 0;
            end else if (!hab) begin
                mVal[k] = 0;
            end else begin
                mIns[k] = mem[mPc[k]];
                mVal[k] = 1;
                if (mCnt[k] < 255) mCnt[k] = mCnt[k] + 1;
                if (mPc[k] == mFim[k]) runState[k] = 2;
                else mPc[k] = (mPc[k] + 1) % 256;
            end
        end else begin
            mVal[k] = 0;
            if (ini) begin
                mPc[k]      = mIni[k];
                mCnt[k]     = 0;
                runState[k] = 1;
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("A endereco",  enderecoA,       8'(mPc[0]));
        checkValue("A instrucao", instrucaoA,      8'(mIns[0]));
        checkValue("A valida",    {7'd0, validaA}, 8'(mVal[0]));
        checkValue("A parado",    {7'd0, paradoA}, 8'(runState[0] == 2));
        checkValue("A contador",  contadorA,       8'(mCnt[0]));
        checkValue("B endereco",  enderecoB,       8'(mPc[1]));
        checkValue("B instrucao", instrucaoB,      8'(mIns[1]));
        checkValue("B valida",    {7'd0, validaB}, 8'(mVal[1]));
        checkValue("B parado",    {7'd0, paradoB}, 8'(runState[1] == 2));
        checkValue("B contador",  contadorB,       8'(mCnt[1]));
    endtask

    // Drive inputs at the falling edge, let the rising edge act, then
    // compare both instances with the model just after it.
    task automatic applyStimulus(input bit ini, input bit hab, input bit des, input int tgt);
        @(negedge clock);
        iniciar        = ini;
        habilita       = hab;
        desvio         = des;
        enderecoDesvio = 8'(tgt);
        @(posedge clock);
        modelEdge(0, ini, hab, des, tgt);
        modelEdge(1, ini, hab, des, tgt);
        #1;
        checkOutput();
    endtask

    task automatic stepUntilA(input logic [7:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && enderecoA !== target; i++) applyStimulus(0, 1, 0, 0);
        checkValue(tag, enderecoA, target);
    endtask

    int savedCnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0]   = 8'hB0;
        mem[1]   = 8'hB5;
        mem[2]   = 8'hBA;
        mem[3]   = 8'hBF;
        mem[4]   = 8'hBF;
        mem[5]   = 8'hC4;
        mem[20]  = 8'h45;
        mem[39]  = 8'h18;
        mem[41]  = 8'hB0;
        mem[100] = 8'h18;

        resetN = 1'b0;
        iniciar = 1'b0;
        habilita = 1'b0;
        desvio = 1'b0;
        enderecoDesvio = 8'h00;
        modelReset();
        @(negedge clock);
        @(negedge clock);
        checkOutput();
        resetN = 1'b1;

        $display("[TB] start and first fetches");
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkValue("first capture A", instrucaoA, 8'hB0);
        checkValue("first capture B", instrucaoB, 8'hB0);
        checkValue("first endereco A", enderecoA, 8'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkValue("fourth capture A", instrucaoA, 8'hBF);

        $display("[TB] full runs to halt");
        for (int i = 0; i < 60 && paradoA !== 1'b1; i++) applyStimulus(0, 1, 0, 0);
        checkValue("Alg1 parado", {7'd0, paradoA}, 8'd1);
        checkValue("Alg1 last capture", instrucaoA, 8'h18);
        checkValue("Alg1 contador", contadorA, 8'd40);
        checkValue("Alg1 endereco", enderecoA, 8'd39);
        for (int i = 0; i < 40 && paradoB !== 1'b1; i++) applyStimulus(0, 1, 0, 0);
        checkValue("Alg2 parado", {7'd0, paradoB}, 8'd1);
        checkValue("Alg2 last capture", instrucaoB, 8'h18);
        checkValue("Alg2 contador", contadorB, 8'd60);
        applyStimulus(0, 1, 1, 7);
        checkValue("halted ignores desvio", enderecoA, 8'd39);
        checkValue("halted valida", {7'd0, validaA}, 8'd0);

        $display("[TB] stall");
        applyStimulus(1, 1, 0, 0);
        stepUntilA(8'd5, 20, "reach pc5");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkValue("stall endereco", enderecoA, 8'd5);
            checkValue("stall instrucao", instrucaoA, 8'hBF);
        end
        applyStimulus(0, 1, 0, 0);
        checkValue("after stall", instrucaoA, 8'hC4);

        $display("[TB] branches");
        stepUntilA(8'd10, 20, "reach pc10");
        savedCnt = int'(contadorA);
        applyStimulus(0, 1, 1, 20);
        checkValue("branch endereco", enderecoA, 8'd20);
        checkValue("branch no count", contadorA, 8'(savedCnt));
        applyStimulus(0, 1, 0, 0);
        checkValue("branch target capture", instrucaoA, 8'h45);
        applyStimulus(0, 0, 1, 10);
        checkValue("branch beats stall", enderecoA, 8'd10);
        applyStimulus(0, 1, 1, 255);
        applyStimulus(0, 1, 0, 0);
        checkValue("wrap endereco", enderecoA, 8'h00);

        $display("[TB] counter saturation");
        for (int loop = 0; loop < 10; loop++) begin
            for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 1, 1, 0);
        end
        checkValue("contador saturates", contadorA, 8'hFF);

        $display("[TB] async reset mid-run");
        stepUntilA(8'd12, 20, "reach pc12");
        #2;
        resetN = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkValue("idle after reset", enderecoA, 8'd0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 16) == 0, ($urandom % 4) != 0,
                          ($urandom % 10) == 0, int'($urandom % 256));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch stage for the 8-bit Redux-V datapath, directly upstream of the instruction memory. It holds the program counter and drives the memory address. It captures the memory's combinational output into an instruction register for the decoder. It also handles start, stall, branch redirect and end-of-program halt.

Parameters:
ENDERECO_INICIAL, 8'd0, PC load value at reset and on every start (41 selects Alg2).
ENDERECO_FIM, 8'd39, address of the last program instruction; fetching it ends the run.

Ports:
clock  input  1  single system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
iniciar  input  1  start pulse; honoured only in OCIOSO or PARADO.
habilita  input  1  fetch enable; 0 = stall.
desvio  input  1  branch taken, from downstream.
endereco_desvio  input  8  branch target.
instrucao_mem  input  8  data from instruction memory (combinational on endereco).
endereco  output  8  address to instruction memory; always equals pc.
instrucao  output  8  instruction register.
valida  output  1  instrucao was newly captured this cycle.
parado  output  1  run finished.
contador_instrucoes  output  8  valid fetches since last start; saturates at 255.

Behaviour:
- Reset is asynchronous on reset_n low.
  - Values: state=OCIOSO, pc=ENDERECO_INICIAL, instrucao=8'h00, valida=0, parado=0, contador_instrucoes=0.
  - Reset asserted mid-run aborts the run immediately, with no completion of an in-flight fetch.
- endereco = pc in every state; it is a combinational copy of the register.
- Memory is combinational, so the fetch latency is 1 cycle: instrucao_mem at edge n is captured into instrucao at edge n, and valida is high for the following cycle.
- State OCIOSO: valida=0, parado=0.
  - iniciar=1 causes pc<=ENDERECO_INICIAL, contador<=0, next=BUSCA.
- State BUSCA, resolved per clock edge in this priority order:
  1. desvio=1: pc<=endereco_desvio, valida<=0, instrucao held, no count, no halt check. Desvio applies even when habilita=0.
  2. habilita=0: pc, instrucao and contador held; valida<=0.
  3. habilita=1 and pc==ENDERECO_FIM: instrucao<=instrucao_mem, valida<=1, contador++ (saturating), pc held, next=PARADO.
  4. habilita=1, other addresses: instrucao<=instrucao_mem, valida<=1, contador++ (saturating), pc<=pc+1.
- PC increment is modulo 256: 8'hFF wraps to 8'h00 with no flag.
- State PARADO: parado=1, valida=0; pc, instrucao and contador held.
  - desvio and habilita are ignored.
  - iniciar=1 causes parado<=0, pc<=ENDERECO_INICIAL, contador<=0, next=BUSCA.
- iniciar is ignored while in BUSCA.
- No X-detection on instrucao_mem: the end of a program is defined solely by ENDERECO_FIM.
- All outputs are registered except endereco.

Test Plan:
- Reset then start: with defaults, pulse iniciar and hold habilita=1.
  - instrucao=8'hB0 with valida=1 after the first BUSCA edge, then 8'hB5, 8'hBA, 8'hBF.
  - endereco steps 0,1,2,3.
- Full Alg1 run: habilita=1 throughout.
  - Last capture is 8'h18 from address 39, then parado=1 and contador_instrucoes=40.
  - endereco stays at 39 and valida=0 thereafter.
- Stall: drop habilita for 3 cycles at pc=5.
  - endereco stays 5, instrucao stays 8'hBF, valida=0.
  - After release, the next capture is 8'hC4.
- Branch, and branch beating stall: desvio=1 with endereco_desvio=8'd20 at pc=10.
  - The next edge gives pc=20, valida=0, no count.
  - The following capture is 8'h45.
  - Repeat with habilita=0: the redirect still occurs.
- Alg2 and wrap-around: instantiate with ENDERECO_INICIAL=41, ENDERECO_FIM=100; first capture 8'hB0, last 8'h18, contador=60.
  - Separately, branch to 8'hFF: the next fetch address is 8'h00.
- Async reset mid-run: assert reset_n=0 between edges at pc=12.
  - Outputs go to reset values immediately, before the next edge.
  - After release, pc=ENDERECO_INICIAL and state is OCIOSO until iniciar.
